// File: rtl/aes256_ctr_stream.sv
// rtl/aes256_ctr_stream.sv - AES-256 CTR stream engine with credit-limited output FIFO and user sideband.
module aes256_ctr_stream #(
  parameter int LAT     = 29,
  parameter int DEPTH_W = 5,
  parameter int CTR_W   = 32,
  parameter int USER_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iv_load,
  input  logic [127:0]      iv,
  input  logic [255:0]      key,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_block,
  input  logic [USER_W-1:0] in_user,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_block,
  output logic [USER_W-1:0] out_user,
  output logic              busy,
  output logic              iv_err
);

  localparam logic [DEPTH_W:0] DEPTH_C  = {1'b1, {DEPTH_W{1'b0}}};
  localparam logic [127:0]     CTR_MASK = {128{1'b1}} >> (128 - CTR_W);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box built from the GF(2^8) inverse (a^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv, sq;
    inv = 8'h01;
    sq  = gmul(a, a);
    for (int i = 0; i < 7; i++) begin
      inv = gmul(inv, sq);
      sq  = gmul(sq, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] v);
    return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
  endfunction

  function automatic logic [127:0] aes256(input logic [255:0] k, input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [127:0] st, rk;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = subword(t);
      end
      w[i] = w[i-8] ^ t;
    end
    st = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 14; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox(st[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) u[4*c+row] = s[4*((c+row)%4)+row];
      if (r != 14) begin
        for (int c = 0; c < 4; c++) begin
          a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
          u[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          u[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          u[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          u[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      for (int i = 0; i < 16; i++) st[127-8*i -: 8] = u[i] ^ rk[127-8*i -: 8];
    end
    return st;
  endfunction

  logic [127:0]          ctr_q, ctr_d, ks;
  logic [DEPTH_W:0]      pend_q, pend_d, wptr_q, rptr_q;
  logic                  iv_err_q, iv_err_d, wr, rd;
  logic [LAT-1:0]        vld_q;
  logic [127:0]          blk_q [LAT];
  logic [USER_W-1:0]     usr_q [LAT];
  logic [USER_W+127:0]   mem [2**DEPTH_W];
  logic [USER_W+127:0]   rd_word;

  assign out_valid = (wptr_q != rptr_q);
  assign rd        = out_valid & out_ready;
  // Credit counts pipeline plus FIFO, so a block leaving this cycle frees a slot immediately.
  assign in_ready  = rst_n && ((pend_q - {{DEPTH_W{1'b0}}, rd}) < DEPTH_C);
  assign wr        = in_valid & in_ready;
  assign busy      = (pend_q != '0);
  assign iv_err    = iv_err_q;
  assign rd_word   = mem[rptr_q[DEPTH_W-1:0]];
  assign out_block = rd_word[127:0];
  assign out_user  = rd_word[USER_W+127:128];

  always_comb ks = aes256(key, ctr_q);

  always_comb begin
    ctr_d    = ctr_q;
    iv_err_d = iv_err_q;
    if (wr) ctr_d = (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);
    else if (iv_load && !busy) ctr_d = iv;
    if (iv_load && (busy || wr)) iv_err_d = 1'b1;
    pend_d = pend_q - {{DEPTH_W{1'b0}}, rd} + {{DEPTH_W{1'b0}}, wr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_q    <= '0;
      pend_q   <= '0;
      iv_err_q <= 1'b0;
      vld_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
    end else begin
      ctr_q    <= ctr_d;
      pend_q   <= pend_d;
      iv_err_q <= iv_err_d;
      vld_q[0] <= wr;
      for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
      if (vld_q[LAT-1]) wptr_q <= wptr_q + 1'b1;
      if (rd) rptr_q <= rptr_q + 1'b1;
    end
  end

  // Keystream is folded in at acceptance, so later key changes cannot disturb blocks in flight.
  always_ff @(posedge clk) begin
    blk_q[0] <= in_block ^ ks;
    usr_q[0] <= in_user;
    for (int i = 1; i < LAT; i++) begin
      blk_q[i] <= blk_q[i-1];
      usr_q[i] <= usr_q[i-1];
    end
    if (vld_q[LAT-1]) mem[wptr_q[DEPTH_W-1:0]] <= {usr_q[LAT-1], blk_q[LAT-1]};
  end

endmodule

// File: tb/tb_aes256_ctr_stream.sv
// tb/tb_aes256_ctr_stream.sv - directed vector bench for aes256_ctr_stream.
module tb_aes256_ctr_stream;
  localparam int LAT = 29, DEPTH_W = 5, DEPTH = 32, CTR_W = 32, USER_W = 8;
  localparam logic [255:0] K2  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] IV2 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] ZCT = 128'hdc95c078a2408989ad48a21492842087;

  logic clk = 1'b0, rst_n = 1'b0;
  logic iv_load = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [127:0] iv = '0, in_block = '0;
  logic [255:0] key = '0;
  logic [USER_W-1:0] in_user = '0;
  logic in_ready, out_valid, busy, iv_err;
  logic [127:0] out_block;
  logic [USER_W-1:0] out_user;

  always #5 clk = ~clk;

  aes256_ctr_stream #(.LAT(LAT), .DEPTH_W(DEPTH_W), .CTR_W(CTR_W), .USER_W(USER_W)) dut (
    .clk(clk), .rst_n(rst_n), .iv_load(iv_load), .iv(iv), .key(key),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block), .in_user(in_user),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .out_user(out_user),
    .busy(busy), .iv_err(iv_err)
  );

  typedef struct { logic [127:0] pt; logic [USER_W-1:0] user; logic [127:0] ct; } vec_t;
  typedef struct packed { logic [USER_W-1:0] user; logic [127:0] blk; } rx_t;
  vec_t vecs [4];
  rx_t  rx_q [$];
  int   n_chk = 0, n_fail = 0;

  always @(negedge clk) if (rst_n && out_valid && out_ready) rx_q.push_back({out_user, out_block});

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [127:0] b, input logic [USER_W-1:0] u, output bit ok);
    int n = 0;
    in_valid = 1'b1; in_block = b; in_user = u;
    #1;
    while (!in_ready && n < 2000) begin @(negedge clk); #1; n++; end
    ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_iv(input logic [127:0] v);
    iv = v; iv_load = 1'b1;
    @(negedge clk);
    iv_load = 1'b0;
  endtask

  task automatic wait_rx(input int cnt, input string name);
    int n = 0;
    while (rx_q.size() < cnt && n < 500) begin @(negedge clk); n++; end
    chk(name, rx_q.size(), cnt);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 500) begin @(negedge clk); n++; end
    chk(name, busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int acc;
    logic [127:0] held;
    vecs[0] = '{128'h6bc1bee22e409f96e93d7e117393172a, 8'h01, 128'h601ec313775789a5b7a7f504bbf3d228};
    vecs[1] = '{128'hae2d8a571e03ac9c9eb76fac45af8e51, 8'h02, 128'hf443e3ca4d62b59aca84e990cacaf5c5};
    vecs[2] = '{128'h30c81c46a35ce411e5fbc1191a0a52ef, 8'h03, 128'h2b0930daa23de94ce87017ba2d84988d};
    vecs[3] = '{128'hf69f2445df4f9b17ad2b417be66c3710, 8'h04, 128'hdfc9c58db67aada613c2dd08457941a6};

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_iv_err", iv_err, 1'b0);
    rst_n = 1'b1;
    #1 chk("post_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // T1: single block, exact latency
    key = '0;
    load_iv('0);
    send('0, 8'h11, ok);
    chk("t1_accept", ok, 1'b1);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k == LAT - 1) chk("t1_early_valid", out_valid, 1'b0);
      if (k == LAT) begin
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_block", out_block, ZCT);
        chk("t1_user", out_user, 8'h11);
      end
    end
    wait_rx(1, "t1_count");
    rx_q.delete();
    wait_idle("t1_idle");

    // T2: SP800-38A CTR-AES256 vectors back to back
    key = K2;
    load_iv(IV2);
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].pt, vecs[i].user, ok);
      chk("t2_accept", ok, 1'b1);
    end
    wait_rx(4, "t2_count");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_block%0d", i), rx_q[i].blk, vecs[i].ct);
      chk($sformatf("t2_user%0d", i), rx_q[i].user, vecs[i].user);
    end
    rx_q.delete();
    wait_idle("t2_idle");

    // T3: counter wrap without carry into upper bits
    key = '0;
    load_iv(128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);
    send('0, 8'h21, ok);
    send('0, 8'h22, ok);
    wait_rx(2, "t3_count");
    chk("t3_wrap_block", rx_q[1].blk, ZCT);
    chk("t3_users", {rx_q[0].user, rx_q[1].user}, {8'h21, 8'h22});
    rx_q.delete();
    wait_idle("t3_idle");

    // T4: backpressure fills exactly DEPTH credits, then drains in order
    key = K2;
    load_iv(IV2);
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < DEPTH + LAT + 8; c++) begin
      in_valid = 1'b1;
      if (acc < 4) in_block = vecs[acc].pt;
      else in_block = '0;
      in_user = 8'h40 + acc[7:0];
      #1;
      if (in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    chk("t4_accepted", acc, DEPTH);
    chk("t4_full_ready", in_ready, 1'b0);
    held = out_block;
    repeat (3) @(negedge clk);
    chk("t4_hold", out_block, held);
    out_ready = 1'b1;
    wait_rx(DEPTH, "t4_count");
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("t4_user%0d", i), rx_q[i].user, 8'h40 + i[7:0]);
      if (i < 4) chk($sformatf("t4_block%0d", i), rx_q[i].blk, vecs[i].ct);
    end
    wait_idle("t4_idle");
    #1 chk("t4_ready_back", in_ready, 1'b1);
    rx_q.delete();
    @(negedge clk);

    // T5: iv_load while busy is ignored and flagged
    chk("t5_err_before", iv_err, 1'b0);
    load_iv(IV2);
    send(vecs[0].pt, vecs[0].user, ok);
    send(vecs[1].pt, vecs[1].user, ok);
    load_iv('0);
    #1 chk("t5_err_set", iv_err, 1'b1);
    @(negedge clk);
    send(vecs[2].pt, vecs[2].user, ok);
    send(vecs[3].pt, vecs[3].user, ok);
    wait_rx(4, "t5_count");
    for (int i = 0; i < 4; i++) chk($sformatf("t5_block%0d", i), rx_q[i].blk, vecs[i].ct);
    wait_idle("t5_idle");
    chk("t5_err_sticky", iv_err, 1'b1);
    rx_q.delete();

    // T6: reset with 10 blocks pending discards them
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(vecs[i % 4].pt, 8'h70 + i[7:0], ok);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_in_ready", in_ready, 1'b0);
    chk("t6_iv_err", iv_err, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    rx_q.delete();
    @(negedge clk);
    load_iv(IV2);
    send(vecs[0].pt, 8'h99, ok);
    wait_rx(1, "t6_wait");
    repeat (LAT + 10) @(negedge clk);
    chk("t6_only_new", rx_q.size(), 1);
    chk("t6_block", rx_q[0].blk, vecs[0].ct);
    chk("t6_user", rx_q[0].user, 8'h99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
